// File: rtl/fb_clk_div.sv
// Runtime-programmable feedback clock divider: divides clk by N (2..2^DIV_W-1) with 50% duty,
// using a negedge half-cycle extension for odd N. Ratio and enable changes land only on period boundaries.
module fb_clk_div #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_fb,
    output logic [DIV_W-1:0] div_cur,
    output logic             upd_pending,
    output logic             period_start,
    output logic             load_err
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    if (DIV_RESET < 2 || DIV_RESET > (2 ** DIV_W) - 1) begin : g_bad_div_reset
        $error("fb_clk_div: DIV_RESET out of range 2..2^DIV_W-1");
    end

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_shd;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic             boundary;
    logic             run_nxt;
    logic             load_ok;
    logic             pos_q;
    logic             neg_q;

    // Parking keeps cnt on the last count of the (possibly just updated) ratio,
    // so the next enabled posedge is always treated as a boundary.
    always_comb begin
        boundary = (cnt == div_cur - ONE);
        div_nxt  = div_cur;
        cnt_nxt  = cnt + ONE;
        run_nxt  = 1'b1;
        if (boundary) begin
            if (upd_pending) begin
                div_nxt = div_shd;
            end
            if (en) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = div_nxt - ONE;
                run_nxt = 1'b0;
            end
        end
        load_ok = div_load && (div_in >= TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= RST_DIV - ONE;
            div_cur      <= RST_DIV;
            div_shd      <= RST_DIV;
            upd_pending  <= 1'b0;
            pos_q        <= 1'b0;
            period_start <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            div_cur      <= div_nxt;
            upd_pending  <= load_ok || (upd_pending && !boundary);
            if (load_ok) begin
                div_shd <= div_in;
            end
            pos_q        <= run_nxt && (cnt_nxt < (div_nxt >> 1));
            period_start <= run_nxt && (cnt_nxt == '0);
            load_err     <= div_load && !load_ok;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // neg_q is always low across a boundary, so switching the odd select there cannot glitch.
    assign clk_fb = pos_q | (neg_q & div_cur[0]);

endmodule

// File: doc/fb_clk_div.md
# fb_clk_div

Runtime-programmable integer feedback clock divider for the PLL feedback path. It divides `clk` by any N from 2 to 2^DIV_W-1 with 50% duty cycle for both even and odd N. Odd ratios use a negative-edge half-cycle extension. Ratio changes and enable/disable take effect only at period boundaries, so `clk_fb` never carries a truncated or glitched pulse.

## Interface
- `DIV_W`, default 8: width of the ratio field.
- `DIV_RESET`, default 3: ratio in force after reset. Legal range is 2..2^DIV_W-1; an out-of-range value is a static elaboration error.

Ports:
- `clk` input, 1 bit: the only clock. Both edges are used.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: run enable. Sampled on posedge.
- `div_load` input, 1 bit: one-cycle request to stage `div_in`. Sampled on posedge.
- `div_in` input, DIV_W bits: requested ratio N.
- `clk_fb` output, 1 bit: divided clock. Glitch-free; driven only from flops through an OR.
- `div_cur` output, DIV_W bits: ratio currently in force.
- `upd_pending` output, 1 bit: a staged ratio is waiting for the next boundary.
- `period_start` output, 1 bit: one-cycle pulse, registered in the posedge domain, high in the cycle in which `clk_fb` rises.
- `load_err` output, 1 bit: one-cycle pulse when `div_load` carries N < 2.

## Operation
- State: counter `cnt` (DIV_W bits), `div_cur`, shadow ratio `div_shd`, `upd_pending`, posedge flop `pos_q`, negedge flop `neg_q`.
- Reset values:
  - `cnt` = DIV_RESET-1 (the parked/last count). Outputs `div_cur` = DIV_RESET.
  - `div_shd` = DIV_RESET.
  - `upd_pending`, `pos_q`, `neg_q`, `period_start`, `load_err` all 0.
  - Result: `clk_fb` = 0 during reset.
- Counting on posedge:
  - If `cnt` < `div_cur`-1, then `cnt` increments.
  - If `cnt` = `div_cur`-1 (the boundary):
    - If `en`=1, `cnt` wraps to 0. If `upd_pending`=1, `div_cur` takes `div_shd` and `upd_pending` clears, both in the same edge.
    - If `en`=0, `cnt` holds at `div_cur`-1 (parked). A pending update is still applied.
- High-phase length: H = floor(`div_cur`/2), computed from the ratio that applies to the next count.
- `pos_q` is registered on posedge as (next `cnt` < H) AND running. `pos_q` is 0 while parked.
- `neg_q` samples `pos_q` on every negedge.
- `clk_fb` output:
  - Even N: `clk_fb` = `pos_q`.
  - Odd N: `clk_fb` = `pos_q` | `neg_q`. This adds a half cycle, giving N/2 cycles high and N/2 cycles low.
  - The odd/even select is registered with `div_cur` at the boundary, so it never changes mid-period.
- Loads:
  - `div_load`=1 with `div_in` ≥ 2: `div_shd` takes `div_in` and `upd_pending` is set.
  - A load while already pending overwrites `div_shd`; the last value wins.
  - A load in the same cycle as the boundary applies the previous shadow value, then stages the new one.
  - `div_load`=1 with `div_in` < 2: request is ignored, `load_err` pulses for one cycle, and the shadow and pending state are unchanged.
- Enable:
  - Deasserting `en` mid-period completes the current period, then parks.
  - Reasserting `en` while parked: `clk_fb` rises at the first posedge that samples `en`=1.

## Timing
- The first `clk_fb` rising edge after reset release is at the first posedge sampling `en`=1. `period_start` is high in that same cycle.
- `clk_fb` rising edges are aligned to posedges of `clk`.
- `clk_fb` falling edges:
  - Even N: on the posedge H cycles after the rise.
  - Odd N: on the negedge H+0.5 cycles after the rise.
- Period is exactly `div_cur` clk cycles; consecutive `period_start` pulses are `div_cur` cycles apart.
- Ratio update latency: new N is in force from the first boundary after the load. Maximum latency is old N cycles after `div_load`.
- `div_cur` changes only at a boundary, in the same edge that `period_start` rises for the new period.
- Asynchronous reset mid-period:
  - `clk_fb` drops immediately. `neg_q` is also asynchronously cleared.
  - The staged ratio is lost and `div_cur` returns to DIV_RESET.

## Test plan
- Reset, `en`=1, default N=3: `clk_fb` high for 1.5 cycles and low for 1.5; `period_start` every 3 cycles; `div_cur`=3.
- Load N=4 mid-period: the current 3-cycle period completes, then 2-high/2-low. `upd_pending` is 1 until the boundary.
- Load N=5 and then N=8 before the boundary: only 8 is applied (4 high/4 low). N=5 is never output.
- Load N=0 and N=1: `load_err` pulses once each; `div_cur` and `upd_pending` are unchanged.
- Deassert `en` at `cnt`=0 with N=7: the 3.5-high/3.5-low period completes, then `clk_fb`=0. Reassert `en`: a rising edge at the first posedge, with `period_start` high.
- Assert `rst_n`=0 with N=255 and `clk_fb` high: `clk_fb`=0 immediately and `div_cur`=3. After release, resumes at N=3.
